keypad_hit_scanner: RTL and testbench

//   Player-side front end for the mole game. Scans a 4x4 active-low button matrix and debounces it.

---
 rtl/keypad_hit_scanner.sv | 239 +++++++++++++++++++++++
 tb/tb_keypad_hit_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/keypad_hit_scanner.sv
// Scans a 4x4 active-low keypad, debounces whole frames and turns each accepted
// press into a single-cycle one-hot Hit_point pulse (bit = col*4+row).
module keypad_hit_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        Clk,
  input  logic        Set,
  input  logic        Enable,
  input  logic [3:0]  Row_in,
  output logic [3:0]  Col_out,
  output logic [15:0] Hit_point,
  output logic        Key_valid,
  output logic [3:0]  Key_addr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_PRESS = 3'd1,
    ST_CONFIRM    = 3'd2,
    ST_HELD       = 3'd3,
    ST_RELEASE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } frame_cls_t;

  function automatic frame_cls_t classify(input logic [15:0] f);
    frame_cls_t c;
    if (f == 16'h0000) begin
      c = CLS_NONE;
    end else if ((f & (f - 16'h0001)) != 16'h0000) begin
      c = CLS_MULTI;
    end else begin
      c = CLS_SINGLE;
    end
    return c;
  endfunction

  function automatic logic [3:0] onehot_index(input logic [15:0] f);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = idx | ({4{f[i]}} & 4'(i));
    end
    return idx;
  endfunction

  logic [1:0]       col_r;
  logic [DIV_W-1:0] div_r;
  logic [15:0]      frame_r;
  logic [15:0]      snap_r;
  logic             eval_r;
  logic [3:0]       col_out_r;

  logic             last_s;
  logic             frame_done_s;
  logic [1:0]       col_next_s;
  logic [15:0]      frame_next_s;

  state_t           state_r, state_nxt_s;
  logic [3:0]       cand_r, cand_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [15:0]      hit_r, hit_nxt_s;
  logic             key_valid_r, valid_nxt_s;
  logic [3:0]       key_addr_r, addr_nxt_s;
  frame_cls_t       cls_s;
  logic [3:0]       idx_s;

  // Scan timing and the in-progress frame with the current column's rows merged in.
  always_comb begin
    last_s       = (div_r == DIV_LAST);
    frame_done_s = last_s && (col_r == 2'd3);
    col_next_s   = last_s ? (col_r + 2'd1) : col_r;
    frame_next_s = frame_r;
    if (last_s) begin
      frame_next_s[{col_r, 2'b00} +: 4] = ~Row_in;
    end else begin
      frame_next_s = frame_r;
    end
    cls_s = classify(snap_r);
    idx_s = onehot_index(snap_r);
  end

  // Column divider, column drive, frame capture and snapshot handoff.
  always_ff @(posedge Clk or posedge Set) begin
    if (Set) begin
      col_r     <= 2'd0;
      div_r     <= {DIV_W{1'b0}};
      frame_r   <= 16'h0000;
      snap_r    <= 16'h0000;
      eval_r    <= 1'b0;
      col_out_r <= 4'hF;
    end else if (!Enable) begin
      col_r     <= 2'd0;
      div_r     <= {DIV_W{1'b0}};
      frame_r   <= 16'h0000;
      snap_r    <= 16'h0000;
      eval_r    <= 1'b0;
      col_out_r <= 4'hF;
    end else begin
      col_r     <= col_next_s;
      div_r     <= last_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
      frame_r   <= frame_next_s;
      snap_r    <= frame_done_s ? frame_next_s : snap_r;
      eval_r    <= frame_done_s;
      col_out_r <= ~(4'b0001 << col_next_s);
    end
  end

  // Debounce FSM: moves only on the cycle a completed frame is presented.
  always_comb begin
    state_nxt_s = state_r;
    cand_nxt_s  = cand_r;
    cnt_nxt_s   = cnt_r;
    hit_nxt_s   = 16'h0000;
    valid_nxt_s = key_valid_r;
    addr_nxt_s  = key_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (Enable) begin
          state_nxt_s = ST_WAIT_PRESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_PRESS: begin
        if (eval_r && (cls_s == CLS_SINGLE)) begin
          cand_nxt_s = idx_s;
          if (DEBOUNCE == 1) begin
            hit_nxt_s   = 16'h0001 << idx_s;
            valid_nxt_s = 1'b1;
            addr_nxt_s  = idx_s;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_HELD;
          end else begin
            cnt_nxt_s   = CNT_ONE;
            state_nxt_s = ST_CONFIRM;
          end
        end else begin
          state_nxt_s = ST_WAIT_PRESS;
        end
      end
      ST_CONFIRM: begin
        if (!eval_r) begin
          state_nxt_s = ST_CONFIRM;
        end else if (cls_s != CLS_SINGLE) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_WAIT_PRESS;
        end else if (idx_s != cand_r) begin
          cand_nxt_s = idx_s;
          cnt_nxt_s  = CNT_ONE;
        end else if (cnt_r == CNT_LAST) begin
          hit_nxt_s   = 16'h0001 << cand_r;
          valid_nxt_s = 1'b1;
          addr_nxt_s  = cand_r;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_HELD;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (eval_r && (cls_s == CLS_NONE)) begin
          if (DEBOUNCE == 1) begin
            valid_nxt_s = 1'b0;
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = ST_WAIT_PRESS;
          end else begin
            cnt_nxt_s   = CNT_ONE;
            state_nxt_s = ST_RELEASE;
          end
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_RELEASE: begin
        if (!eval_r) begin
          state_nxt_s = ST_RELEASE;
        end else if (cls_s != CLS_NONE) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_HELD;
        end else if (cnt_r == CNT_LAST) begin
          valid_nxt_s = 1'b0;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_WAIT_PRESS;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state and registered outputs; a dropped Enable discards any pending hit.
  always_ff @(posedge Clk or posedge Set) begin
    if (Set) begin
      state_r     <= ST_IDLE;
      cand_r      <= 4'd0;
      cnt_r       <= CNT_ZERO;
      hit_r       <= 16'h0000;
      key_valid_r <= 1'b0;
      key_addr_r  <= 4'd0;
    end else if (!Enable) begin
      state_r     <= ST_IDLE;
      cand_r      <= 4'd0;
      cnt_r       <= CNT_ZERO;
      hit_r       <= 16'h0000;
      key_valid_r <= 1'b0;
      key_addr_r  <= key_addr_r;
    end else begin
      state_r     <= state_nxt_s;
      cand_r      <= cand_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hit_r       <= hit_nxt_s;
      key_valid_r <= valid_nxt_s;
      key_addr_r  <= addr_nxt_s;
    end
  end

  assign Col_out   = col_out_r;
  assign Hit_point = hit_r;
  assign Key_valid = key_valid_r;
  assign Key_addr  = key_addr_r;

endmodule

// File: tb/tb_keypad_hit_scanner.sv
// Directed bench for keypad_hit_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames)
// and a behavioural keypad that pulls rows low for pressed cells in the driven column.
module tb_keypad_hit_scanner;

  logic        Clk = 1'b0;
  logic        Set = 1'b1;
  logic        Enable = 1'b0;
  logic [3:0]  Row_in;
  logic [3:0]  Col_out;
  logic [15:0] Hit_point;
  logic        Key_valid;
  logic [3:0]  Key_addr;

  logic [15:0] mask = 16'h0000;
  int          total = 0;
  int          bad = 0;
  int          ecount = 0;
  int          hit_cnt = 0;
  int          hit_edge = 0;
  logic [15:0] hit_val = 16'h0000;

  keypad_hit_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .Clk(Clk), .Set(Set), .Enable(Enable), .Row_in(Row_in),
    .Col_out(Col_out), .Hit_point(Hit_point), .Key_valid(Key_valid), .Key_addr(Key_addr)
  );

  function automatic logic [3:0] row_model(input logic [3:0] col, input logic [15:0] m);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) r = r & ~m[c*4 +: 4];
    end
    return r;
  endfunction

  assign Row_in = row_model(Col_out, mask);

  always #5 Clk = ~Clk;

  always @(posedge Clk) ecount <= ecount + 1;

  // Record every cycle in which a hit bit is visible; a wide pulse counts twice.
  always @(negedge Clk) begin
    if (Hit_point != 16'h0000) begin
      hit_cnt  <= hit_cnt + 1;
      hit_val  <= Hit_point;
      hit_edge <= ecount;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_frames(input int n);
    repeat (16 * n) @(posedge Clk);
    #1;
  endtask

  initial begin
    int base;
    int e0;
    logic [3:0] exp_col;

    Enable = 1'b1;
    mask   = 16'h0000;
    repeat (5) @(posedge Clk);
    #1;
    check_eq("rst_col", Col_out, 4'hF);
    check_eq("rst_hit", Hit_point, 16'h0000);
    check_eq("rst_valid", Key_valid, 1'b0);
    check_eq("rst_addr", Key_addr, 4'h0);
    Set = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      @(posedge Clk);
      #1;
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check_eq("scan_col", Col_out, exp_col);
    end
    run_frames(1);
    check_eq("idle_hits", hit_cnt, 0);
    check_eq("idle_valid", Key_valid, 1'b0);

    // Clean press of cell 9
    base = hit_cnt; e0 = ecount;
    mask = 16'h0200;
    run_frames(6);
    check_eq("clean_cnt", hit_cnt, base + 1);
    check_eq("clean_val", hit_val, 16'h0200);
    check_eq("clean_edge", hit_edge, e0 + 49);
    check_eq("clean_addr", Key_addr, 4'd9);
    check_eq("clean_valid", Key_valid, 1'b1);
    mask = 16'h0000;
    run_frames(4);
    check_eq("clean_rel_valid", Key_valid, 1'b0);

    // Bounce on cell 5
    base = hit_cnt;
    mask = 16'h0020; run_frames(2);
    mask = 16'h0000; run_frames(1);
    check_eq("bounce_early", hit_cnt, base);
    e0 = ecount;
    mask = 16'h0020; run_frames(4);
    check_eq("bounce_cnt", hit_cnt, base + 1);
    check_eq("bounce_val", hit_val, 16'h0020);
    check_eq("bounce_edge", hit_edge, e0 + 49);
    mask = 16'h0000; run_frames(4);

    // Two keys together, then one released
    base = hit_cnt;
    mask = 16'h8001; run_frames(5);
    check_eq("multi_none", hit_cnt, base);
    e0 = ecount;
    mask = 16'h0001; run_frames(4);
    check_eq("multi_cnt", hit_cnt, base + 1);
    check_eq("multi_val", hit_val, 16'h0001);
    check_eq("multi_edge", hit_edge, e0 + 49);
    check_eq("multi_addr", Key_addr, 4'd0);
    mask = 16'h0000; run_frames(4);

    // Hold, short release, full release
    base = hit_cnt; e0 = ecount;
    mask = 16'h0008; run_frames(10);
    check_eq("hold_cnt", hit_cnt, base + 1);
    check_eq("hold_val", hit_val, 16'h0008);
    check_eq("hold_edge", hit_edge, e0 + 49);
    mask = 16'h0000; run_frames(2);
    mask = 16'h0008; run_frames(2);
    check_eq("repress_cnt", hit_cnt, base + 1);
    check_eq("repress_valid", Key_valid, 1'b1);
    mask = 16'h0000; run_frames(3);
    e0 = ecount;
    mask = 16'h0008; run_frames(4);
    check_eq("newpress_cnt", hit_cnt, base + 2);
    check_eq("newpress_val", hit_val, 16'h0008);
    check_eq("newpress_edge", hit_edge, e0 + 49);
    mask = 16'h0000; run_frames(4);

    // Enable dropped mid-debounce
    base = hit_cnt;
    mask = 16'h0080; run_frames(2);
    repeat (2) @(posedge Clk);
    #1;
    Enable = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check_eq("dis_col", Col_out, 4'hF);
    check_eq("dis_valid", Key_valid, 1'b0);
    check_eq("dis_addr", Key_addr, 4'd3);
    check_eq("dis_cnt", hit_cnt, base);
    Enable = 1'b1;
    e0 = ecount;
    run_frames(4);
    check_eq("reen_cnt", hit_cnt, base + 1);
    check_eq("reen_val", hit_val, 16'h0080);
    check_eq("reen_edge", hit_edge, e0 + 49);
    check_eq("reen_addr", Key_addr, 4'd7);
    check_eq("reen_valid", Key_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
